// File: rtl/ps2_mouse_responder_if.sv
// ps2_mouse_responder_if: byte-level link between the PS/2 line layer (master) and the mouse responder (slave).
interface ps2_mouse_responder_if;
   logic       rx;
   logic [7:0] rx_data;
   logic       tx;
   logic [7:0] tx_data;
   logic       tx_ok;
   logic       tx_fail;
   logic       tx_idle;
   modport master (output rx, rx_data, tx_ok, tx_fail, tx_idle, input tx, tx_data);
   modport slave (input rx, rx_data, tx_ok, tx_fail, tx_idle, output tx, tx_data);
endinterface

// File: rtl/ps2_mouse_responder.sv
// ps2_mouse_responder: device-side PS/2 mouse command responder with movement accumulation and 3-byte packets.
// Define PS2_MOUSE_STREAM_EN to enable periodic stream-mode reports every SAMPLE_TICKS cycles.
`ifndef CLOCK_SPEED
`define CLOCK_SPEED 50000000
`endif
module ps2_mouse_responder #(
   parameter int SAMPLE_TICKS = `CLOCK_SPEED / 100,
   parameter bit BAT_ON_RESET = 1'b1
) (
   input  logic                    iClk,
   input  logic                    iRst,
   ps2_mouse_responder_if.slave    link,
   input  logic                    iMove,
   input  logic signed [8:0]       iDx,
   input  logic signed [8:0]       iDy,
   input  logic [2:0]              iBtn,
   output logic                    oEnabled,
   output logic                    oBusy
);
   localparam logic [7:0] ACK = 8'hFA;
   typedef enum logic {CMD, ARG} cmd_t;
   typedef enum logic {TX_IDLE, TX_WAIT} tx_t;
   cmd_t cmd_q, cmd_d;
   tx_t tx_q;
   logic [31:0] fifo_q, ld_w, last_sh;
   logic [2:0] cnt_q, ld_n;
   logic [7:0] last_q;
   logic last_v_q, bat_q, scale_q, en_d, scale_d, ld, ld_dat;
   logic signed [8:0] x_q, y_q;
   logic xo_q, yo_q, eb_cap, stream_cap, clr;
   logic [9:0] xa, ya, xs, ys;
   logic [23:0] pkt_raw, pkt_scl;
   // Saturating add; result is {overflow, 9-bit value}.
   function automatic logic [9:0] acc(input logic signed [9:0] b, input logic signed [8:0] d);
      logic signed [9:0] s;
      s = b + {d[8], d};
      return s > 10'sd255 ? {1'b1, 9'h0FF} : s < -10'sd256 ? {1'b1, 9'h100} : {1'b0, s[8:0]};
   endfunction
   // 2:1 scaling on magnitude, sign kept; result is {overflow, 9-bit value}.
   function automatic logic [9:0] scale(input logic [8:0] v);
      logic [9:0] m, r, nr;
      m = v[8] ? 10'd512 - {1'b0, v} : {1'b0, v};
      r = m == 10'd0 ? 10'd0 : m < 10'd3 ? 10'd1 : m == 10'd3 ? 10'd3 :
          m == 10'd4 ? 10'd6 : m == 10'd5 ? 10'd9 : m << 1;
      nr = 10'd0 - r;
      if (v[8]) return r > 10'd256 ? {1'b1, 9'h100} : {1'b0, nr[8:0]};
      return r > 10'd255 ? {1'b1, 9'h0FF} : {1'b0, r[8:0]};
   endfunction
   assign xs = scale_q ? scale(x_q) : {1'b0, x_q};
   assign ys = scale_q ? scale(y_q) : {1'b0, y_q};
   assign pkt_raw = {yo_q, xo_q, y_q[8], x_q[8], 1'b1, iBtn, x_q[7:0], y_q[7:0]};
   assign pkt_scl = {yo_q | ys[9], xo_q | xs[9], ys[8], xs[8], 1'b1, iBtn, xs[7:0], ys[7:0]};
   assign eb_cap = link.rx && cmd_q == CMD && link.rx_data == 8'hEB;
   assign clr = eb_cap || stream_cap ||
                (link.rx && cmd_q == CMD && (link.rx_data == 8'hFF || link.rx_data == 8'hF6));
   assign xa = acc(clr ? 10'sd0 : {x_q[8], x_q}, iMove ? iDx : 9'sd0);
   assign ya = acc(clr ? 10'sd0 : {y_q[8], y_q}, iMove ? iDy : 9'sd0);
   assign oBusy = cnt_q != 3'd0 || tx_q == TX_WAIT;
`ifdef PS2_MOUSE_STREAM_EN
   logic [31:0] tick_q;
   logic pend_q, gate;
   logic [2:0] btn_q;
   assign gate = oEnabled && cmd_q == CMD && cnt_q == 3'd0 && tx_q == TX_IDLE && !link.rx && !bat_q;
   assign stream_cap = gate && pend_q && (x_q != 9'sd0 || y_q != 9'sd0 || iBtn != btn_q);
   // An expiry stays pending until the report gate opens, then either reports or is discarded.
   always_ff @(posedge iClk)
      if (iRst) begin
         tick_q <= 32'(SAMPLE_TICKS - 1);
         pend_q <= 1'b0;
         btn_q  <= 3'd0;
      end else begin
         tick_q <= tick_q == 32'd0 ? 32'(SAMPLE_TICKS - 1) : tick_q - 32'd1;
         pend_q <= tick_q == 32'd0 || (pend_q && !gate);
         if (eb_cap || stream_cap) btn_q <= iBtn;
      end
`else
   assign stream_cap = 1'b0;
`endif
   // Every push lands in an empty (or just-flushed) FIFO, so replies are loaded as a whole word.
   always_comb begin
      cmd_d = cmd_q;
      en_d = oEnabled;
      scale_d = scale_q;
      ld = 1'b0;
      ld_n = 3'd0;
      ld_w = 32'd0;
      ld_dat = 1'b0;
      if (link.rx) begin
         ld = 1'b1;
         ld_n = 3'd1;
         ld_w = {ACK, 24'd0};
         if (cmd_q == ARG) cmd_d = CMD;
         else case (link.rx_data)
            8'hFF: begin ld_n = 3'd3; ld_w = {ACK, 8'hAA, 16'd0}; ld_dat = 1'b1; en_d = 1'b0; scale_d = 1'b0; end
            8'hF6: begin en_d = 1'b0; scale_d = 1'b0; end
            8'hE6: scale_d = 1'b0;
            8'hE7: scale_d = 1'b1;
            8'hF4: en_d = 1'b1;
            8'hF5: en_d = 1'b0;
            8'hF2: begin ld_n = 3'd2; ld_dat = 1'b1; end
            8'hEB: begin ld_n = 3'd4; ld_w = {ACK, pkt_raw}; ld_dat = 1'b1; end
            8'hF3, 8'hE8: cmd_d = ARG;
            8'hFE: ld_w = {last_v_q ? last_q : ACK, 24'd0};
            default: ld_w = {8'hFE, 24'd0};
         endcase
      end else if (bat_q) begin
         ld = 1'b1;
         ld_n = 3'd2;
         ld_w = {8'hAA, 24'd0};
         ld_dat = 1'b1;
      end else if (stream_cap) begin
         ld = 1'b1;
         ld_n = 3'd3;
         ld_w = {pkt_scl, 8'd0};
         ld_dat = 1'b1;
      end
      last_sh = ld_w << {ld_n[1:0] - 2'd1, 3'b000};
   end
   always_ff @(posedge iClk)
      if (iRst) begin
         cmd_q <= CMD;
         tx_q <= TX_IDLE;
         oEnabled <= 1'b0;
         scale_q <= 1'b0;
         x_q <= 9'sd0;
         y_q <= 9'sd0;
         xo_q <= 1'b0;
         yo_q <= 1'b0;
         fifo_q <= 32'd0;
         cnt_q <= 3'd0;
         link.tx <= 1'b0;
         link.tx_data <= 8'd0;
         bat_q <= BAT_ON_RESET;
         last_q <= 8'd0;
         last_v_q <= 1'b0;
      end else begin
         cmd_q <= cmd_d;
         oEnabled <= en_d;
         scale_q <= scale_d;
         bat_q <= 1'b0;
         x_q <= xa[8:0];
         y_q <= ya[8:0];
         xo_q <= (!clr && xo_q) || xa[9];
         yo_q <= (!clr && yo_q) || ya[9];
         if (ld && ld_dat) begin
            last_q <= last_sh[31:24];
            last_v_q <= 1'b1;
         end
         link.tx <= 1'b0;
         if (ld) begin
            fifo_q <= ld_w;
            cnt_q <= ld_n;
            tx_q <= TX_IDLE;
         end else if (tx_q == TX_IDLE && cnt_q != 3'd0 && link.tx_idle) begin
            link.tx <= 1'b1;
            link.tx_data <= fifo_q[31:24];
            tx_q <= TX_WAIT;
         end else if (tx_q == TX_WAIT && link.tx_ok) begin
            fifo_q <= fifo_q << 8;
            cnt_q <= cnt_q - 3'd1;
            tx_q <= TX_IDLE;
         end else if (tx_q == TX_WAIT && link.tx_fail) tx_q <= TX_IDLE;
      end
endmodule

// File: tb/tb_ps2_mouse_responder.sv
// tb_ps2_mouse_responder: directed bench with a reply scoreboard acting as the PS/2 line layer.
module tb_ps2_mouse_responder;
   localparam int TICKS = 50;
   logic iClk = 1'b0, iRst = 1'b1, iMove = 1'b0;
   logic signed [8:0] iDx = 9'sd0, iDy = 9'sd0;
   logic [2:0] iBtn = 3'd0;
   logic oEnabled, oBusy;
   int checks = 0, failures = 0;
   logic [7:0] exp_q[$];
   ps2_mouse_responder_if link();
   always #5 iClk = ~iClk;
   ps2_mouse_responder #(.SAMPLE_TICKS(TICKS), .BAT_ON_RESET(1'b1)) dut (
      .iClk(iClk), .iRst(iRst), .link(link), .iMove(iMove), .iDx(iDx), .iDy(iDy),
      .iBtn(iBtn), .oEnabled(oEnabled), .oBusy(oBusy));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic host(input logic [7:0] b);
      link.rx = 1'b1;
      link.rx_data = b;
      @(negedge iClk);
      link.rx = 1'b0;
   endtask
   task automatic move(input logic signed [8:0] dx, input logic signed [8:0] dy);
      iMove = 1'b1;
      iDx = dx;
      iDy = dy;
      @(negedge iClk);
      iMove = 1'b0;
   endtask
   task automatic recv(input bit fail);
      int n = 0;
      while (!link.tx && n < 200) begin
         @(negedge iClk);
         n++;
      end
      if (!link.tx || exp_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL tx_byte observed=%s expected_pending=%0d", link.tx ? "extra" : "timeout", exp_q.size());
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
         chk("tx_byte", {24'd0, link.tx_data}, {24'd0, exp_q[0]});
         if (!fail) void'(exp_q.pop_front());
         link.tx_ok = !fail;
         link.tx_fail = fail;
         @(negedge iClk);
         link.tx_ok = 1'b0;
         link.tx_fail = 1'b0;
      end
   endtask
   task automatic drain();
      while (exp_q.size() != 0) recv(1'b0);
   endtask
   task automatic quiet(input int cyc);
      int seen = 0;
      repeat (cyc) begin
         @(negedge iClk);
         if (link.tx) seen++;
      end
      chk("no_tx", seen, 0);
   endtask
   initial begin
      link.rx = 1'b0;
      link.rx_data = 8'd0;
      link.tx_ok = 1'b0;
      link.tx_fail = 1'b0;
      link.tx_idle = 1'b1;
      repeat (3) @(negedge iClk);
      chk("rst_tx", {31'd0, link.tx}, 0);
      chk("rst_tx_data", {24'd0, link.tx_data}, 0);
      chk("rst_enabled", {31'd0, oEnabled}, 0);
      chk("rst_busy", {31'd0, oBusy}, 0);
      iRst = 1'b0;
      @(negedge iClk);
      chk("busy_after_release", {31'd0, oBusy}, 1);
      exp_q.push_back(8'hAA); exp_q.push_back(8'h00);
      drain();
      chk("busy_after_bat", {31'd0, oBusy}, 0);
      host(8'hFF);
      exp_q.push_back(8'hFA); exp_q.push_back(8'hAA); exp_q.push_back(8'h00);
      drain();
      host(8'hF6); exp_q.push_back(8'hFA); drain();
      host(8'hE7); exp_q.push_back(8'hFA); drain();
      iBtn = 3'b001;
      move(9'sd5, -9'sd3);
      host(8'hEB);
      exp_q.push_back(8'hFA); exp_q.push_back(8'h29); exp_q.push_back(8'h05); exp_q.push_back(8'hFD);
      drain();
      iBtn = 3'b000;
      host(8'hEB);
      exp_q.push_back(8'hFA); exp_q.push_back(8'h08); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      drain();
      move(9'sd200, 9'sd0);
      move(9'sd200, 9'sd0);
      host(8'hEB);
      exp_q.push_back(8'hFA); exp_q.push_back(8'h48); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
      drain();
      host(8'hEB);
      exp_q.push_back(8'hFA); exp_q.push_back(8'h08); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      drain();
      host(8'hF2); exp_q.push_back(8'hFA); exp_q.push_back(8'h00); drain();
      host(8'hFE); exp_q.push_back(8'h00); drain();
      host(8'h12); exp_q.push_back(8'hFE); drain();
      host(8'hF3); exp_q.push_back(8'hFA); drain();
      host(8'h64); exp_q.push_back(8'hFA); drain();
      host(8'hF4); exp_q.push_back(8'hFA); drain();
      chk("enabled_f4", {31'd0, oEnabled}, 1);
      host(8'hF5); exp_q.push_back(8'hFA);
      recv(1'b1);
      recv(1'b0);
      chk("enabled_f5", {31'd0, oEnabled}, 0);
      move(9'sd1, 9'sd0);
      host(8'hEB); exp_q.push_back(8'hFA);
      recv(1'b0);
      @(negedge iClk);
      chk("packet_in_flight", {31'd0, link.tx}, 1);
      host(8'hF5); exp_q.push_back(8'hFA);
      drain();
      quiet(20);
      chk("busy_after_flush", {31'd0, oBusy}, 0);
`ifdef PS2_MOUSE_STREAM_EN
      host(8'hF4); exp_q.push_back(8'hFA); drain();
      host(8'hE7); exp_q.push_back(8'hFA); drain();
      move(9'sd4, 9'sd0);
      exp_q.push_back(8'h08); exp_q.push_back(8'h06); exp_q.push_back(8'h00);
      drain();
      quiet(3 * TICKS);
      host(8'hF5); exp_q.push_back(8'hFA); drain();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
